// File: rtl/sync_ram_pkg.sv
// Shared types and constants for the byte-enable synchronous RAM.
// Clear-sequencer state encoding and the byte width used for lane slicing.
package sync_ram_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/ram_clear_seq.sv
// Full-memory zero-clear sequencer: walks a word counter from 0 to DEPTH-1,
// one word per cycle, and exposes busy plus its FSM state for observation.
module ram_clear_seq
    import sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_req_i,
    output logic                  busy_o,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o,
    output logic                  state_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_o     = 1'b0;
        clr_we_o   = 1'b0;
        clr_addr_o = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (clr_req_i) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                busy_o   = 1'b1;
                clr_we_o = 1'b1;
                // The last word ends the sweep; the counter never wraps.
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/sync_ram_be.sv
// Simple dual-port synchronous RAM with per-byte write enables and a zero-clear sweep.
// Define SYNC_RAM_BYPASS_EN to forward same-cycle write bytes to a colliding read.
module sync_ram_be
    import sync_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic [DATA_WIDTH/8-1:0]    wr_be,
    input  logic                       rd_en,
    input  logic [ADDR_WIDTH-1:0]      rd_addr,
    input  logic                       clr_req,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_valid,
    output logic                       busy
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_word;
    logic                  rd_valid_q;
    logic                  clr_we, clr_we_seq, clr_state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_accept, rd_accept;

    ram_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_req_i  (clr_req),
        .busy_o     (busy),
        .clr_we_o   (clr_we_seq),
        .clr_addr_o (clr_addr),
        .state_o    (clr_state)
    );

    // Reset drops every memory access, including an in-flight clear write.
    assign clr_we    = clr_we_seq && (clr_state == CLEAR) && !rst;
    assign wr_accept = wr_en && !busy && !rst;
    // Read handshake: rd_en is taken when idle and out of reset; rd_valid pulses
    // for exactly one cycle one edge later, and rd_data holds until the next take.
    assign rd_accept = rd_en && !busy && !rst;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_accept) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem_q[rd_addr];
`ifdef SYNC_RAM_BYPASS_EN
        if (wr_accept && (wr_addr == rd_addr)) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_be[b]) begin
                    rd_word[b*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_data_q <= rd_word;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sync_ram_be.sv
// Directed and randomized bench for sync_ram_be against a word-array reference model.
// Honours SYNC_RAM_BYPASS_EN when computing collision expectations.
module tb_sync_ram_be;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    wr_be = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          clr_req = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_data = '0;

    sync_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .clr_req  (clr_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-lane merge expressed as mask arithmetic.
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [3:0] be);
        logic [DW-1:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m = m | (32'hFF << (8 * b));
        end
        return (old_w & ~m) | (new_w & m);
    endfunction

    // One idle-state cycle: apply a write and/or read, update the model, check outputs.
    task automatic access(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic [3:0] be, input logic re, input logic [AW-1:0] ra);
        logic [DW-1:0] e;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        if (re) begin
            e = ref_mem[ra];
`ifdef SYNC_RAM_BYPASS_EN
            if (we && (wa == ra)) e = merge(e, wd, be);
`endif
            exp_q.push_back(e);
        end
        if (we) ref_mem[wa] = merge(ref_mem[wa], wd, be);
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rd_valid", {31'b0, rd_valid}, {31'b0, re});
        if (re) begin
            e = exp_q.pop_front();
            check("rd_data", rd_data, e);
            last_data = e;
        end else begin
            check("rd_data_hold", rd_data, last_data);
        end
    endtask

    initial begin
        int busy_cycles;
        logic [DW-1:0] keep_val;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        rst = 1'b0;

        // Full clear: busy exactly DEPTH cycles, reads ignored meanwhile
        clr_req = 1'b1;
        tick();
        check("clr_busy_rise", {31'b0, busy}, 32'd1);
        busy_cycles = 1;
        rd_en = 1'b1;
        rd_addr = 10'h3FF;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            tick();
            check("busy_rd_valid", {31'b0, rd_valid}, 32'd0);
            if (!busy) break;
            busy_cycles++;
        end
        clr_req = 1'b0;
        rd_en = 1'b0;
        check("clr_busy_cycles", busy_cycles, DEPTH);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        access(1'b0, '0, '0, 4'h0, 1'b1, 10'h3FF);
        check("clr_last_word", rd_data, 32'h0);

        // Full-word write then read, one-cycle valid pulse
        access(1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 1'b0, '0);
        access(1'b0, '0, '0, 4'h0, 1'b1, 10'h005);
        check("full_word", rd_data, 32'hDEADBEEF);
        access(1'b0, '0, '0, 4'h0, 1'b0, '0);

        // Partial byte write
        access(1'b1, 10'h005, 32'h11223344, 4'b0101, 1'b0, '0);
        access(1'b0, '0, '0, 4'h0, 1'b1, 10'h005);
        check("byte_merge", rd_data, 32'hDE22BE44);

        // All-zero byte enables leave memory unchanged
        access(1'b1, 10'h005, 32'hFFFFFFFF, 4'b0000, 1'b0, '0);
        access(1'b0, '0, '0, 4'h0, 1'b1, 10'h005);
        check("be_zero", rd_data, 32'hDE22BE44);

        // Same-cycle write and read at one address
        access(1'b1, 10'h010, 32'hCAFEF00D, 4'hF, 1'b1, 10'h010);
`ifdef SYNC_RAM_BYPASS_EN
        check("collide", rd_data, 32'hCAFEF00D);
`else
        check("collide", rd_data, 32'h00000000);
`endif
        access(1'b0, '0, '0, 4'h0, 1'b1, 10'h010);
        check("collide_after", rd_data, 32'hCAFEF00D);

        // Randomized traffic in a small window to force collisions
        for (int i = 0; i < 300; i++) begin
            access(1'($urandom_range(0, 1)), AW'(10'h040 + $urandom_range(0, 7)), $urandom,
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   AW'(10'h040 + $urandom_range(0, 7)));
        end

        // Reset ten cycles into a clear aborts it and drops same-cycle accesses
        keep_val = $urandom;
        access(1'b1, 10'h200, keep_val, 4'hF, 1'b0, '0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr2_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 10'h200; wr_data = ~keep_val; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 10'h200;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("abort_rd_data", rd_data, 32'd0);
        rst = 1'b0;
        last_data = '0;
        tick();
        check("post_abort_busy", {31'b0, busy}, 32'd0);
        access(1'b0, '0, '0, 4'h0, 1'b1, 10'h200);
        check("retained_0x200", rd_data, keep_val);
        access(1'b0, '0, '0, 4'h0, 1'b1, 10'h043);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_ram_be.md
SYNC_RAM_BE -- requirements
Module: sync_ram_be

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 10: address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Port clk  input  1: single clock, all logic on rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port wr_en  input  1: write request.
REQ-006 Port wr_addr  input  ADDR_WIDTH: write address.
REQ-007 Port wr_data  input  DATA_WIDTH: write data.
REQ-008 Port wr_be  input  DATA_WIDTH/8: byte enables, bit i covers wr_data[8i+7:8i].
REQ-009 Port rd_en  input  1: read request.
REQ-010 Port rd_addr  input  ADDR_WIDTH: read address.
REQ-011 Port clr_req  input  1: request full-memory zero clear.
REQ-012 Port rd_data  output  DATA_WIDTH: registered read data.
REQ-013 Port rd_valid  output  1: one-cycle pulse, rd_data updated this cycle.
REQ-014 Port busy  output  1: clear sequence in progress.

Function
REQ-015 Write: at an edge with wr_en=1 and busy=0, only bytes with wr_be[i]=1 SHALL be written; wr_be all zero SHALL leave memory unchanged.
REQ-016 Read: rd_en=1 and busy=0 at edge N SHALL give rd_data=mem[rd_addr] and rd_valid=1 after edge N (latency 1).
REQ-017 rd_valid SHALL be 0 in any cycle not following an accepted read; rd_data SHALL hold its last value until the next accepted read.
REQ-018 Independent read and write ports; both SHALL be accepted in the same cycle, including to the same address.
REQ-019 FSM states IDLE, CLEAR; IDLE->CLEAR on clr_req=1; CLEAR->IDLE after the word at address DEPTH-1 is written.
REQ-020 In CLEAR, an internal counter starting at 0 SHALL write all-zero to one word per cycle, incrementing by 1; clear SHALL take exactly DEPTH cycles.
REQ-021 busy SHALL equal (state==CLEAR); it rises the cycle after clr_req is sampled.
REQ-022 While busy=1, wr_en, rd_en and clr_req SHALL be ignored; rd_valid SHALL stay 0.
REQ-023 In the IDLE cycle sampling clr_req=1, the concurrent write and read SHALL still be performed; the clear then overwrites.
REQ-024 Counter SHALL not wrap past DEPTH-1; reaching it SHALL end CLEAR.

Reset
REQ-025 rst=1 SHALL force state=IDLE, counter=0, busy=0, rd_valid=0, rd_data=0 at the next edge.
REQ-026 rst SHALL take priority over all requests; reads and writes in a reset cycle SHALL be dropped.
REQ-027 Memory contents SHALL not be reset; reset mid-CLEAR SHALL abort, leaving words above the counter unchanged.

Configuration
REQ-028 Macro SYNC_RAM_BYPASS_EN defined: same-cycle accepted read and write to equal address SHALL return per-byte merge (enabled bytes from wr_data, others from memory).
REQ-029 Macro SYNC_RAM_BYPASS_EN undefined: that read SHALL return the pre-write memory word.

Structure
REQ-030 Package sync_ram_pkg SHALL hold the state typedef (IDLE, CLEAR) and constant BYTE_WIDTH=8.
REQ-031 One sub-module, ram_clear_seq, SHALL contain the clear FSM, counter and busy; the top holds memory, byte-write and read/bypass logic.

Verification
REQ-032 Write 0xDEADBEEF @0x005 be=4'b1111, read @0x005 -> next cycle rd_data=0xDEADBEEF, rd_valid=1 for one cycle.
REQ-033 Over 0xDEADBEEF write 0x11223344 be=4'b0101 @0x005, read -> 0xDE22BE44.
REQ-034 Same cycle write 0xCAFEF00D be=4'b1111 and read @0x010 (old 0x0) -> 0xCAFEF00D with bypass macro, 0x00000000 without.
REQ-035 Pulse clr_req (DEPTH=1024) -> busy high exactly 1024 cycles; reads during busy give rd_valid=0; afterwards read @0x3FF -> 0x0.
REQ-036 Assert rst 10 cycles into clear -> busy=0, rd_valid=0, rd_data=0 next cycle; word @0x200 written before clear retains its value.
